side_info_parser: RTL and testbench

- Consumes the MPEG-1 Layer III side-information bytes that the SD demultiplexer steers out after the header/CRC: 17 bytes for mono, 32 bytes otherwise.
- Unpacks the per-frame fields, then emits one granule/channel record per gr/ch pair with a valid pulse.
- Its consumers are the main-data/bit-reservoir and Huffman stages.

---
 rtl/mp3_pkg.sv | 49 ++++
 rtl/side_info_gc_unpack.sv | 51 +++++
 rtl/side_info_parser.sv | 129 ++++++++++++
 tb/tb_side_info_parser.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mp3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mp3_pkg                                                       |
// | Description : Shared MPEG-1 Layer III side-information constants and types |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mp3_pkg;

   localparam logic [1:0] MODE_MONO          = 2'b11;

   // Side-info byte counts (Layer III, MPEG-1)
   localparam logic [5:0] SI_BYTES_MONO      = 6'd17;
   localparam logic [5:0] SI_BYTES_STEREO    = 6'd32;

   // One granule/channel record in the bitstream
   localparam int         GC_BITS            = 59;

   // Per-frame header field widths
   localparam int         MDB_BITS           = 9;
   localparam int         PRIV_BITS_MONO     = 5;
   localparam int         PRIV_BITS_STEREO   = 3;
   localparam int         SCFSI_BITS_PER_CH  = 4;
   localparam logic [8:0] HDR_BITS_MONO      = 9'(MDB_BITS + PRIV_BITS_MONO + SCFSI_BITS_PER_CH);
   localparam logic [8:0] HDR_BITS_STEREO    = 9'(MDB_BITS + PRIV_BITS_STEREO + 2 * SCFSI_BITS_PER_CH);

   typedef struct packed {
      logic [11:0]      part2_3_length;
      logic [8:0]       big_values;
      logic [7:0]       global_gain;
      logic [3:0]       scalefac_compress;
      logic             window_switching_flag;
      logic [1:0]       block_type;
      logic             mixed_block_flag;
      logic [2:0][4:0]  table_select;
      logic [2:0][2:0]  subblock_gain;
      logic [3:0]       region0_count;
      logic [2:0]       region1_count;
      logic             preflag;
      logic             scalefac_scale;
      logic             count1table_select;
   } gc_rec_t;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_FRAME = 1'b1
   } si_state_t;

endpackage
`default_nettype wire

// File: rtl/side_info_gc_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : side_info_gc_unpack                                           |
// | Description : Combinational split of one 59-bit granule/channel record     |
// |               (bit 58 = first bitstream bit) into gc_rec_t                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module side_info_gc_unpack
   import mp3_pkg::*;
(
   input  logic [GC_BITS-1:0] i_bits,
   output gc_rec_t            o_rec
);

   logic w_wsf;
   assign w_wsf = i_bits[25];

   // Fixed fields first, then the 22-bit body whose meaning depends on window switching
   always_comb begin
      o_rec                       = '0;
      o_rec.part2_3_length        = i_bits[58:47];
      o_rec.big_values            = i_bits[46:38];
      o_rec.global_gain           = i_bits[37:30];
      o_rec.scalefac_compress     = i_bits[29:26];
      o_rec.window_switching_flag = w_wsf;
      o_rec.preflag               = i_bits[2];
      o_rec.scalefac_scale        = i_bits[1];
      o_rec.count1table_select    = i_bits[0];
      if (w_wsf) begin
         o_rec.block_type       = i_bits[24:23];
         o_rec.mixed_block_flag = i_bits[22];
         o_rec.table_select[0]  = i_bits[21:17];
         o_rec.table_select[1]  = i_bits[16:12];
         o_rec.table_select[2]  = 5'd0;
         o_rec.subblock_gain[0] = i_bits[11:9];
         o_rec.subblock_gain[1] = i_bits[8:6];
         o_rec.subblock_gain[2] = i_bits[5:3];
         // Region counts are implicit here; pure short blocks use 8, everything else 7
         o_rec.region0_count    = (i_bits[24:23] == 2'b10 && !i_bits[22]) ? 4'd8 : 4'd7;
         o_rec.region1_count    = 3'd0;
      end else begin
         o_rec.table_select[0]  = i_bits[24:20];
         o_rec.table_select[1]  = i_bits[19:15];
         o_rec.table_select[2]  = i_bits[14:10];
         o_rec.region0_count    = i_bits[9:6];
         o_rec.region1_count    = i_bits[5:3];
      end
   end

endmodule
`default_nettype wire

// File: rtl/side_info_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : side_info_parser                                              |
// | Description : Byte-serial MPEG-1 Layer III side-info parser; emits frame   |
// |               header fields and one record per granule/channel pair        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module side_info_parser
   import mp3_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  mode,
   input  logic [7:0]  axiid,
   input  logic        axiiv,
   output logic [8:0]  main_data_begin,
   output logic [4:0]  private_bits,
   output logic [7:0]  scfsi,
   output logic        frame_ov,
   output logic        gc_ov,
   output logic        gc_gr,
   output logic        gc_ch,
   output gc_rec_t     gc_rec,
   output logic        done_ov
);

   si_state_t          r_state;
   logic               r_mono;
   logic [5:0]         r_byte_cnt;
   logic [5:0]         r_last_byte;
   logic [8:0]         r_next_end;    // bit position just past the next field to finish
   logic               r_hdr_done;
   logic [1:0]         r_rec_idx;
   logic [63:0]        r_sr;          // bits retained from earlier bytes

   logic               w_accept;
   logic [71:0]        w_sr_next;     // alignment window: retained bits plus the incoming byte
   logic [5:0]         w_byte_inc;
   logic [8:0]         w_bits_total;
   logic               w_field_done;
   logic [2:0]         w_slack;
   logic [GC_BITS-1:0] w_slice;
   logic               w_last_rec;
   gc_rec_t            w_rec;

   assign w_accept     = (r_state == S_FRAME) && axiiv && !start;
   assign w_sr_next    = {r_sr, axiid};
   assign w_byte_inc   = r_byte_cnt + 6'd1;
   assign w_bits_total = {w_byte_inc, 3'b000};
   assign w_field_done = w_accept && (w_bits_total >= r_next_end);
   // Totals are byte multiples, so only the low bits of the field end set the alignment
   assign w_slack      = 3'd0 - r_next_end[2:0];
   assign w_slice      = GC_BITS'(w_sr_next >> w_slack);
   assign w_last_rec   = (r_rec_idx == (r_mono ? 2'd1 : 2'd3));

   side_info_gc_unpack u_gc_unpack (
      .i_bits (w_slice),
      .o_rec  (w_rec)
   );

   // Frame FSM, bit tracking and registered outputs; at most one field completes per byte
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_mono          <= 1'b0;
         r_byte_cnt      <= '0;
         r_last_byte     <= '0;
         r_next_end      <= '0;
         r_hdr_done      <= 1'b0;
         r_rec_idx       <= '0;
         r_sr            <= '0;
         main_data_begin <= '0;
         private_bits    <= '0;
         scfsi           <= '0;
         frame_ov        <= 1'b0;
         gc_ov           <= 1'b0;
         gc_gr           <= 1'b0;
         gc_ch           <= 1'b0;
         gc_rec          <= '0;
         done_ov         <= 1'b0;
      end else begin
         frame_ov <= 1'b0;
         gc_ov    <= 1'b0;
         done_ov  <= 1'b0;
         if (start) begin
            r_state     <= S_FRAME;
            r_mono      <= (mode == MODE_MONO);
            r_byte_cnt  <= '0;
            r_last_byte <= (mode == MODE_MONO) ? SI_BYTES_MONO - 6'd1 : SI_BYTES_STEREO - 6'd1;
            r_next_end  <= (mode == MODE_MONO) ? HDR_BITS_MONO : HDR_BITS_STEREO;
            r_hdr_done  <= 1'b0;
            r_rec_idx   <= '0;
            r_sr        <= '0;
         end else if (w_accept) begin
            r_sr       <= w_sr_next[63:0];
            r_byte_cnt <= w_byte_inc;
            if (w_field_done) begin
               r_next_end <= r_next_end + 9'(GC_BITS);
               if (!r_hdr_done) begin
                  r_hdr_done <= 1'b1;
                  frame_ov   <= 1'b1;
                  if (r_mono) begin
                     main_data_begin <= w_slice[17:9];
                     private_bits    <= w_slice[8:4];
                     scfsi           <= {w_slice[3:0], 4'b0000};
                  end else begin
                     main_data_begin <= w_slice[19:11];
                     private_bits    <= {2'b00, w_slice[10:8]};
                     scfsi           <= w_slice[7:0];
                  end
               end else begin
                  gc_ov     <= 1'b1;
                  gc_rec    <= w_rec;
                  gc_gr     <= r_mono ? r_rec_idx[0] : r_rec_idx[1];
                  gc_ch     <= r_mono ? 1'b0 : r_rec_idx[0];
                  r_rec_idx <= r_rec_idx + 2'd1;
                  done_ov   <= w_last_rec;
               end
            end
            if (r_byte_cnt == r_last_byte) begin
               r_state <= S_IDLE;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_side_info_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_side_info_parser                                           |
// | Description : Directed self-checking bench for side_info_parser            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_side_info_parser;
   import mp3_pkg::*;

   logic       clk = 1'b0;
   logic       rst, start, axiiv;
   logic [1:0] mode;
   logic [7:0] axiid;
   logic [8:0] main_data_begin;
   logic [4:0] private_bits;
   logic [7:0] scfsi;
   logic       frame_ov, gc_ov, gc_gr, gc_ch, done_ov;
   gc_rec_t    gc_rec;

   side_info_parser dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .mode            (mode),
      .axiid           (axiid),
      .axiiv           (axiiv),
      .main_data_begin (main_data_begin),
      .private_bits    (private_bits),
      .scfsi           (scfsi),
      .frame_ov        (frame_ov),
      .gc_ov           (gc_ov),
      .gc_gr           (gc_gr),
      .gc_ch           (gc_ch),
      .gc_rec          (gc_rec),
      .done_ov         (done_ov)
   );

   // 25 MHz
   always #20 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] pf, pg, pd;       // per-byte pulse masks
   int          spur;             // pulses seen outside a byte-accept cycle
   int          ncap;
   gc_rec_t     cap_rec [4];
   logic [1:0]  cap_grch [4];
   gc_rec_t     exp_ff, exp_a, exp_b;
   logic [255:0] fb_ones, fb_zero, fb_dir;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [1:0] m, input logic with_byte);
      start = 1'b1; mode = m; axiiv = with_byte; axiid = 8'hAA;
      @(posedge clk); #1;
      start = 1'b0; axiiv = 1'b0;
   endtask

   // Byte i is fb[255-8*i -: 8]; pulses are sampled 1 ns after the accepting edge
   task automatic send_frame(input logic [255:0] fb, input int nbytes, input int gap);
      pf = '0; pg = '0; pd = '0; ncap = 0; spur = 0;
      for (int i = 0; i < nbytes; i++) begin
         axiid = fb[255-8*i -: 8];
         axiiv = 1'b1;
         @(posedge clk); #1;
         axiiv = 1'b0;
         pf[i] = frame_ov; pg[i] = gc_ov; pd[i] = done_ov;
         if (gc_ov && ncap < 4) begin
            cap_rec[ncap]  = gc_rec;
            cap_grch[ncap] = {gc_gr, gc_ch};
            ncap++;
         end
         repeat (gap) begin
            @(posedge clk); #1;
            if (frame_ov || gc_ov || done_ov) spur++;
         end
      end
      repeat (2) begin
         @(posedge clk); #1;
         if (frame_ov || gc_ov || done_ov) spur++;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; axiiv = 1'b0; axiid = 8'h00; mode = 2'b00;
      fb_ones = '1;
      fb_zero = '0;

      // All-ones record: wsf=1, block_type=3, mixed=1 -> region0 implicit 7
      exp_ff = '0;
      exp_ff.part2_3_length = 12'hFFF; exp_ff.big_values = 9'h1FF;
      exp_ff.global_gain = 8'hFF; exp_ff.scalefac_compress = 4'hF;
      exp_ff.window_switching_flag = 1'b1; exp_ff.block_type = 2'd3;
      exp_ff.mixed_block_flag = 1'b1;
      exp_ff.table_select[0] = 5'd31; exp_ff.table_select[1] = 5'd31;
      exp_ff.subblock_gain[0] = 3'd7; exp_ff.subblock_gain[1] = 3'd7;
      exp_ff.subblock_gain[2] = 3'd7;
      exp_ff.region0_count = 4'd7; exp_ff.region1_count = 3'd0;
      exp_ff.preflag = 1'b1; exp_ff.scalefac_scale = 1'b1;
      exp_ff.count1table_select = 1'b1;

      // Record A: wsf=1, block_type=2, mixed=0 -> region0 implicit 8
      exp_a = '0;
      exp_a.window_switching_flag = 1'b1; exp_a.block_type = 2'd2;
      exp_a.table_select[0] = 5'd3; exp_a.table_select[1] = 5'd17;
      exp_a.subblock_gain[0] = 3'd1; exp_a.subblock_gain[1] = 3'd5;
      exp_a.subblock_gain[2] = 3'd7;
      exp_a.region0_count = 4'd8; exp_a.preflag = 1'b1;
      exp_a.count1table_select = 1'b1;

      // Record B: wsf=0, explicit tables and regions
      exp_b = '0;
      exp_b.part2_3_length = 12'hABC; exp_b.big_values = 9'd300;
      exp_b.global_gain = 8'd200; exp_b.scalefac_compress = 4'd9;
      exp_b.table_select[0] = 5'd1; exp_b.table_select[1] = 5'd2;
      exp_b.table_select[2] = 5'd3;
      exp_b.region0_count = 4'd10; exp_b.region1_count = 3'd5;
      exp_b.scalefac_scale = 1'b1;

      // Stereo frame: header bytes 80 40 -> mdb bits 100000000, private bits 9..11 = 100
      fb_dir = '0;
      fb_dir[255 -: 16] = 16'h8040;
      fb_dir[235 -: 59] = {12'd0, 9'd0, 8'd0, 4'd0, 1'b1, 2'b10, 1'b0, 5'd3, 5'd17,
                           3'd1, 3'd5, 3'd7, 1'b1, 1'b0, 1'b1};       // gr0ch0, bits 20..78
      fb_dir[176 -: 59] = {12'hABC, 9'd300, 8'd200, 4'd9, 1'b0, 5'd1, 5'd2, 5'd3,
                           4'd10, 3'd5, 1'b0, 1'b1, 1'b0};            // gr0ch1, bits 79..137

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_hdr", 128'({main_data_begin, private_bits, scfsi}), 128'(0));
      check("reset_pulses", 128'({frame_ov, gc_ov, done_ov, gc_gr, gc_ch}), 128'(0));
      check("reset_rec", 128'(gc_rec), 128'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Mono, all 0xFF
      do_start(2'b11, 1'b0);
      send_frame(fb_ones, 17, 0);
      check("mono_frame_mask", 128'(pf), 128'(32'h1 << 2));
      check("mono_gc_mask", 128'(pg), 128'((32'h1 << 9) | (32'h1 << 16)));
      check("mono_done_mask", 128'(pd), 128'(32'h1 << 16));
      check("mono_mdb", 128'(main_data_begin), 128'(511));
      check("mono_priv", 128'(private_bits), 128'(31));
      check("mono_scfsi", 128'(scfsi), 128'(8'hF0));
      check("mono_ncap", 128'(ncap), 128'(2));
      check("mono_rec0", 128'(cap_rec[0]), 128'(exp_ff));
      check("mono_rec1", 128'(cap_rec[1]), 128'(exp_ff));
      check("mono_grch", 128'({cap_grch[0], cap_grch[1]}), 128'(4'b00_10));
      check("mono_spur", 128'(spur), 128'(0));

      // Stereo, all zeros
      do_start(2'b00, 1'b0);
      send_frame(fb_zero, 32, 0);
      check("st0_frame_mask", 128'(pf), 128'(32'h1 << 2));
      check("st0_gc_mask", 128'(pg), 128'((32'h1 << 9) | (32'h1 << 17) | (32'h1 << 24) | (32'h1 << 31)));
      check("st0_done_mask", 128'(pd), 128'(32'h1 << 31));
      check("st0_grch", 128'({cap_grch[0], cap_grch[1], cap_grch[2], cap_grch[3]}), 128'(8'b00_01_10_11));
      check("st0_recs", 128'({cap_rec[0], cap_rec[1]}), 128'(0));
      check("st0_recs_gr1", 128'({cap_rec[2], cap_rec[3]}), 128'(0));
      check("st0_hdr", 128'({main_data_begin, private_bits, scfsi}), 128'(0));

      // Stereo directed frame, back to back, then with 3-cycle gaps
      for (int g = 0; g < 4; g += 3) begin
         do_start(2'b01, 1'b0);
         send_frame(fb_dir, 32, g);
         check($sformatf("dir_g%0d_mdb", g), 128'(main_data_begin), 128'(256));
         check($sformatf("dir_g%0d_priv", g), 128'(private_bits), 128'(4));
         check($sformatf("dir_g%0d_scfsi", g), 128'(scfsi), 128'(0));
         check($sformatf("dir_g%0d_rec_a", g), 128'(cap_rec[0]), 128'(exp_a));
         check($sformatf("dir_g%0d_rec_b", g), 128'(cap_rec[1]), 128'(exp_b));
         check($sformatf("dir_g%0d_gc_mask", g), 128'(pg),
               128'((32'h1 << 9) | (32'h1 << 17) | (32'h1 << 24) | (32'h1 << 31)));
         check($sformatf("dir_g%0d_frame_done", g), 128'({pf, pd}), 128'({32'h1 << 2, 32'h1 << 31}));
         check($sformatf("dir_g%0d_spur", g), 128'(spur), 128'(0));
      end

      // Restart at byte 10 of a stereo frame, with a byte on the start cycle
      do_start(2'b00, 1'b0);
      send_frame(fb_zero, 10, 0);
      check("abort_pre_gc_mask", 128'(pg), 128'(32'h1 << 9));
      do_start(2'b11, 1'b1);
      send_frame(fb_ones, 17, 0);
      check("abort_frame_mask", 128'(pf), 128'(32'h1 << 2));
      check("abort_gc_mask", 128'(pg), 128'((32'h1 << 9) | (32'h1 << 16)));
      check("abort_done_mask", 128'(pd), 128'(32'h1 << 16));
      check("abort_rec0", 128'(cap_rec[0]), 128'(exp_ff));
      check("abort_hdr", 128'({main_data_begin, scfsi}), 128'({9'd511, 8'hF0}));

      // Reset at byte 5, then bytes without start are ignored
      do_start(2'b11, 1'b0);
      send_frame(fb_ones, 5, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid_hdr", 128'({main_data_begin, private_bits, scfsi}), 128'(0));
      check("rst_mid_rec", 128'({gc_rec, gc_gr, gc_ch}), 128'(0));
      send_frame(fb_ones, 17, 0);
      check("rst_idle_pulses", 128'({pf, pg, pd}), 128'(0));
      check("rst_idle_hdr", 128'(main_data_begin), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
